// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet protocol.
// Opcodes, header layout and the host FSM state encoding.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_DIV  = 8'h03;

  localparam int         HDR_BYTES = 4;
  localparam logic [7:0] RSV_BYTE  = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_OPND,
    S_RESP,
    S_DONE
  } host_state_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uart_alu_byte_ser.sv
// 32-bit word to 4-byte LSB-first serializer with a holding register.
// Ports: en gates intake, in_* word stream, out_* byte stream, last on 4th byte.
module uart_alu_byte_ser
  import uart_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        last
);

  logic [31:0] hold_q;
  logic        full_q;
  logic [1:0]  idx_q;
  logic        fire;
  logic        take;

  assign fire      = full_q & out_ready;
  assign last      = fire & (idx_q == 2'd3);
  // Refill in the cycle the last byte leaves keeps bytes back-to-back.
  assign in_ready  = en & (~full_q | last);
  assign take      = in_valid & in_ready;
  assign out_valid = full_q;
  assign out_data  = hold_q[{idx_q, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (take) begin
      hold_q <= in_data;
      full_q <= 1'b1;
      idx_q  <= '0;
    end else if (last) begin
      full_q <= 1'b0;
      idx_q  <= '0;
    end else if (fire) begin
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_alu_host.sv
// Host initiator: serializes opcode+operands to UART TX, collects 4-byte result.
// Ports: cmd_*, opnd_* in; tx_* / rx_* AXI-Stream bytes; rsp_* result; busy_o.
module uart_alu_host
  import uart_alu_pkg::*;
#(
  parameter int MAX_OPS        = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = $clog2(MAX_OPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_opcode_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             opnd_valid_i,
  output logic             opnd_ready_o,
  input  logic [31:0]      opnd_data_i,
  output logic [7:0]       tx_tdata_o,
  output logic             tx_tvalid_o,
  input  logic             tx_tready_i,
  input  logic [7:0]       rx_tdata_i,
  input  logic             rx_tvalid_i,
  output logic             rx_tready_o,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  host_state_t st_q, st_d;

  logic [7:0]       op_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] in_q;
  logic [CNT_W-1:0] out_q;
  logic [1:0]       idx_q;
  logic [TO_W-1:0]  to_q;
  logic [31:0]      res_q;
  logic             err_q;

  logic [15:0] len;
  logic [7:0]  hdr_byte;
  logic        cmd_fire;
  logic        cmd_ok;
  logic        tx_fire;
  logic        rx_fire;
  logic        to_hit;
  logic        ser_en;
  logic        ser_last;
  logic        ser_valid;
  logic [7:0]  ser_data;

  assign cmd_ready_o = (st_q == S_IDLE);
  assign rx_tready_o = (st_q != S_DONE);
  assign busy_o      = (st_q != S_IDLE);
  assign rsp_valid_o = (st_q == S_DONE);
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_data_o  = (rsp_valid_o && !err_q) ? res_q : '0;

  assign cmd_fire = cmd_valid_i & cmd_ready_o;
  assign cmd_ok   = op_known(cmd_opcode_i)
                  && (cmd_count_i >= CNT_W'(2))
                  && (cmd_count_i <= CNT_W'(MAX_OPS));
  assign tx_fire  = tx_tvalid_o & tx_tready_i;
  assign rx_fire  = rx_tvalid_i & rx_tready_o;
  assign to_hit   = (to_q == TO_LAST);

  assign len = 16'(HDR_BYTES) + (16'(n_q) << 2);

  always_comb begin
    hdr_byte = op_q;
    case (idx_q)
      2'd1:    hdr_byte = RSV_BYTE;
      2'd2:    hdr_byte = len[7:0];
      2'd3:    hdr_byte = len[15:8];
      default: hdr_byte = op_q;
    endcase
  end

  // First operand is loaded while the last header byte leaves.
  assign ser_en = ((st_q == S_OPND)
                || (st_q == S_HDR && idx_q == 2'd3 && tx_tready_i))
                && (in_q != n_q);

  uart_alu_byte_ser u_ser (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .en        (ser_en),
    .in_valid  (opnd_valid_i),
    .in_ready  (opnd_ready_o),
    .in_data   (opnd_data_i),
    .out_data  (ser_data),
    .out_valid (ser_valid),
    .out_ready (tx_tready_i && st_q == S_OPND),
    .last      (ser_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st_q <= S_IDLE;
    else         st_q <= st_d;
  end

  always_comb begin
    st_d        = st_q;
    tx_tvalid_o = 1'b0;
    tx_tdata_o  = '0;
    unique case (st_q)
      S_IDLE: begin
        if (cmd_valid_i) st_d = cmd_ok ? S_HDR : S_DONE;
      end
      S_HDR: begin
        tx_tvalid_o = 1'b1;
        tx_tdata_o  = hdr_byte;
        if (tx_tready_i && idx_q == 2'd3) st_d = S_OPND;
      end
      S_OPND: begin
        tx_tvalid_o = ser_valid;
        tx_tdata_o  = ser_data;
        if (ser_last && out_q == n_q - CNT_W'(1)) st_d = S_RESP;
      end
      S_RESP: begin
        // A byte arriving on the timeout cycle wins.
        if (rx_fire ? (idx_q == 2'd3) : to_hit) st_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready_i) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= '0;
      n_q   <= '0;
      in_q  <= '0;
      out_q <= '0;
      idx_q <= '0;
      to_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_q  <= cmd_opcode_i;
        n_q   <= cmd_count_i;
        in_q  <= '0;
        out_q <= '0;
        idx_q <= '0;
        err_q <= ~cmd_ok;
      end
      // idx wraps 3->0, so RESP starts at byte 0.
      if (st_q == S_HDR && tx_fire) idx_q <= idx_q + 2'd1;
      if (opnd_valid_i && opnd_ready_o) in_q <= in_q + CNT_W'(1);
      if (ser_last) out_q <= out_q + CNT_W'(1);
      if (st_q == S_OPND) to_q <= '0;
      if (st_q == S_RESP) begin
        if (rx_fire) begin
          res_q[{idx_q, 3'b000} +: 8] <= rx_tdata_i;
          idx_q <= idx_q + 2'd1;
          to_q  <= '0;
        end else begin
          to_q <= to_q + TO_W'(1);
          if (to_hit) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_host.sv
// Directed bench for uart_alu_host: packet bytes, stalls, errors,
// timeout, stale RX discard and asynchronous reset.
module tb_uart_alu_host;
  import uart_alu_pkg::*;

  localparam int MAX_OPS = 8;
  localparam int TO      = 50;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [7:0]    cmd_opcode_i = '0;
  logic [CW-1:0] cmd_count_i = '0;
  logic          opnd_valid_i = 1'b0;
  logic          opnd_ready_o;
  logic [31:0]   opnd_data_i = '0;
  logic [7:0]    tx_tdata_o;
  logic          tx_tvalid_o;
  logic          tx_tready_i = 1'b1;
  logic [7:0]    rx_tdata_i = '0;
  logic          rx_tvalid_i = 1'b0;
  logic          rx_tready_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [31:0]   rsp_data_o;
  logic          rsp_err_o;
  logic          busy_o;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int tmode = 0;

  uart_alu_host #(
    .MAX_OPS(MAX_OPS),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i),
    .cmd_count_i(cmd_count_i),
    .opnd_valid_i(opnd_valid_i),
    .opnd_ready_o(opnd_ready_o),
    .opnd_data_i(opnd_data_i),
    .tx_tdata_o(tx_tdata_o),
    .tx_tvalid_o(tx_tvalid_o),
    .tx_tready_i(tx_tready_i),
    .rx_tdata_i(rx_tdata_i),
    .rx_tvalid_i(rx_tvalid_i),
    .rx_tready_o(rx_tready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tx_tready_i = (tmode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  logic [7:0] txq[$];
  int         txc[$];
  int         stall_bad = 0;
  logic       st_q = 1'b0;
  logic [7:0] st_d = '0;

  always @(negedge clk) begin
    if (!rst_ni) begin
      st_q = 1'b0;
    end else begin
      if (st_q && (!tx_tvalid_o || tx_tdata_o !== st_d)) stall_bad++;
      st_q = tx_tvalid_o && !tx_tready_i;
      st_d = tx_tdata_o;
      if (tx_tvalid_o && tx_tready_i) begin
        txq.push_back(tx_tdata_o);
        txc.push_back(cyc);
      end
    end
  end

  logic [31:0] opq[$];
  logic        op_take = 1'b0;

  always begin
    @(negedge clk);
    op_take = opnd_valid_i && opnd_ready_o;
    @(posedge clk);
    if (op_take && opq.size() > 0) void'(opq.pop_front());
    #1;
    opnd_valid_i = (opq.size() > 0);
    opnd_data_i  = (opq.size() > 0) ? opq[0] : 32'h0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input int n,
                          output int hs);
    hs = -1;
    cmd_valid_i  = 1'b1;
    cmd_opcode_i = op;
    cmd_count_i  = CW'(n);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready_o) hs = cyc;
      @(posedge clk);
      #1;
      if (hs >= 0) break;
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_rx(input logic [31:0] w, input int cnt,
                         output int last);
    bit got;
    last = -1;
    for (int b = 0; b < cnt; b++) begin
      rx_tvalid_i = 1'b1;
      rx_tdata_i  = w[b*8 +: 8];
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (rx_tready_o) begin
          got  = 1'b1;
          last = cyc;
        end
        @(posedge clk);
        #1;
      end
    end
    rx_tvalid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int c);
    c = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        c = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rsp_ack();
    tick();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({cmd_ready_o, rx_tready_o, tx_tvalid_o, opnd_ready_o,
         busy_o, rsp_valid_o, rsp_err_o} !== 7'b1100000) begin
      errs++;
      $display("FAIL reset_ctl: got %b, required 1100000",
               {cmd_ready_o, rx_tready_o, tx_tvalid_o, opnd_ready_o,
                busy_o, rsp_valid_o, rsp_err_o});
    end
    checks++;
    if (tx_tdata_o !== 8'h00 || rsp_data_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_data: got tx=%h rsp=%h, required 0",
               tx_tdata_o, rsp_data_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int hs, last, c;
    bit ok;
    logic [31:0] d;
    logic [7:0] e[$];
    logic [7:0] g;
    e = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
          8'h07, 8'h00, 8'h00, 8'h00};
    txq.delete(); txc.delete(); tmode = 0;
    opq.push_back(32'd5); opq.push_back(32'd7);
    tick();
    send_cmd(OP_ADD, 2, hs);
    wait_tx(12, ok);
    checks++;
    if (!ok || txq.size() != 12) begin
      errs++;
      $display("FAIL add_tx_count: got %0d, required 12", txq.size());
    end
    for (int i = 0; i < 12; i++) begin
      g = (i < txq.size()) ? txq[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errs++;
        $display("FAIL add_tx[%0d]: got %h, required %h", i, g, e[i]);
      end
    end
    checks++;
    if (txc.size() < 12 || txc[0] != hs + 1 || txc[11] != hs + 12) begin
      errs++;
      $display("FAIL add_tx_latency: got first=%0d last=%0d, required %0d..%0d",
               (txc.size() > 0) ? txc[0] : -1,
               (txc.size() > 11) ? txc[11] : -1, hs + 1, hs + 12);
    end
    feed_rx(32'h0000000C, 4, last);
    wait_rsp(20, c);
    checks++;
    if (c < 0 || c != last + 1) begin
      errs++;
      $display("FAIL add_rsp_latency: got %0d, required %0d", c, last + 1);
    end
    checks++;
    if (rsp_data_o !== 32'h0000000C || rsp_err_o !== 1'b0) begin
      errs++;
      $display("FAIL add_rsp: got data=%h err=%b, required 0000000c/0",
               rsp_data_o, rsp_err_o);
    end
    d = rsp_data_o;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== d) begin
      errs++;
      $display("FAIL add_rsp_hold: got valid=%b data=%h, required 1/%h",
               rsp_valid_o, rsp_data_o, d);
    end
    rsp_ack();
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL add_rsp_clear: got valid=%b busy=%b, required 0/0",
               rsp_valid_o, busy_o);
    end
    tick();
  endtask

  task automatic test_mul_stall();
    int hs, last, c;
    bit ok;
    logic [7:0] e[$];
    logic [7:0] g;
    e = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    txq.delete(); txc.delete(); stall_bad = 0; tmode = 1;
    opq.push_back(32'h11223344); opq.push_back(32'd2); opq.push_back(32'd3);
    tick();
    send_cmd(OP_MUL, 3, hs);
    wait_tx(16, ok);
    tmode = 0;
    checks++;
    if (!ok || txq.size() != 16) begin
      errs++;
      $display("FAIL mul_tx_count: got %0d, required 16", txq.size());
    end
    for (int i = 0; i < 16; i++) begin
      g = (i < txq.size()) ? txq[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errs++;
        $display("FAIL mul_tx[%0d]: got %h, required %h", i, g, e[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errs++;
      $display("FAIL mul_stall_hold: got %0d violations, required 0",
               stall_bad);
    end
    feed_rx(32'h66CD3398, 4, last);
    wait_rsp(20, c);
    checks++;
    if (c < 0 || rsp_data_o !== 32'h66CD3398 || rsp_err_o !== 1'b0) begin
      errs++;
      $display("FAIL mul_rsp: got data=%h err=%b, required 66cd3398/0",
               rsp_data_o, rsp_err_o);
    end
    rsp_ack();
    tick();
  endtask

  task automatic test_invalid();
    int hs, c;
    logic [7:0] ops[3];
    int ns[3];
    ops = '{OP_ADD, 8'h07, OP_ADD};
    ns  = '{1, 2, 9};
    for (int v = 0; v < 3; v++) begin
      txq.delete();
      send_cmd(ops[v], ns[v], hs);
      wait_rsp(10, c);
      checks++;
      if (c < 0 || hs < 0 || c > hs + 2) begin
        errs++;
        $display("FAIL inv%0d_latency: got %0d, required <= %0d",
                 v, c, hs + 2);
      end
      checks++;
      if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0) begin
        errs++;
        $display("FAIL inv%0d_rsp: got err=%b data=%h, required 1/0",
                 v, rsp_err_o, rsp_data_o);
      end
      checks++;
      if (txq.size() != 0) begin
        errs++;
        $display("FAIL inv%0d_tx: got %0d bytes, required 0",
                 v, txq.size());
      end
      rsp_ack();
      tick();
    end
  endtask

  task automatic test_timeout();
    int hs, last, c;
    bit ok;
    txq.delete(); tmode = 0;
    opq.push_back(32'd1); opq.push_back(32'd1);
    tick();
    send_cmd(OP_ADD, 2, hs);
    wait_tx(12, ok);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL to_tx: got %0d bytes, required 12", txq.size());
    end
    feed_rx(32'h0000BEEF, 2, last);
    wait_rsp(200, c);
    // Byte taken at edge ending cycle last; DONE visible 50 edges later.
    checks++;
    if (c < 0 || c != last + 1 + TO) begin
      errs++;
      $display("FAIL to_cycle: got %0d, required %0d", c, last + 1 + TO);
    end
    checks++;
    if (rsp_err_o !== 1'b1 || rsp_data_o !== 32'h0) begin
      errs++;
      $display("FAIL to_rsp: got err=%b data=%h, required 1/0",
               rsp_err_o, rsp_data_o);
    end
    rsp_ack();
    tick();
  endtask

  task automatic test_stale_div();
    int hs, last, c;
    bit ok;
    logic [7:0] e[$];
    logic [7:0] g;
    e = '{8'h03, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00,
          8'h07, 8'h00, 8'h00, 8'h00};
    txq.delete(); tmode = 0;
    rx_tvalid_i = 1'b1; rx_tdata_i = 8'hAA;
    @(negedge clk);
    checks++;
    if (rx_tready_o !== 1'b1 || busy_o !== 1'b0) begin
      errs++;
      $display("FAIL stale_idle: got rdy=%b busy=%b, required 1/0",
               rx_tready_o, busy_o);
    end
    tick();
    rx_tvalid_i = 1'b0;
    opq.push_back(32'd100); opq.push_back(32'd7);
    tick();
    send_cmd(OP_DIV, 2, hs);
    rx_tvalid_i = 1'b1; rx_tdata_i = 8'hAA;
    @(negedge clk);
    checks++;
    if (rx_tready_o !== 1'b1 || tx_tvalid_o !== 1'b1) begin
      errs++;
      $display("FAIL stale_hdr: got rdy=%b txv=%b, required 1/1",
               rx_tready_o, tx_tvalid_o);
    end
    tick();
    rx_tvalid_i = 1'b0;
    wait_tx(12, ok);
    for (int i = 0; i < 12; i++) begin
      g = (i < txq.size()) ? txq[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errs++;
        $display("FAIL div_tx[%0d]: got %h, required %h", i, g, e[i]);
      end
    end
    feed_rx(32'h0000000E, 4, last);
    wait_rsp(20, c);
    checks++;
    if (c < 0 || rsp_data_o !== 32'h0000000E || rsp_err_o !== 1'b0) begin
      errs++;
      $display("FAIL div_rsp: got data=%h err=%b, required 0000000e/0",
               rsp_data_o, rsp_err_o);
    end
    rsp_ack();
    tick();
  endtask

  task automatic test_reset_mid();
    int hs, last, c;
    bit ok;
    txq.delete(); tmode = 0;
    opq.push_back(32'h10); opq.push_back(32'h20);
    tick();
    send_cmd(OP_ADD, 2, hs);
    wait_tx(6, ok);
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({cmd_ready_o, rx_tready_o, tx_tvalid_o, opnd_ready_o,
         busy_o, rsp_valid_o, rsp_err_o} !== 7'b1100000
        || tx_tdata_o !== 8'h00) begin
      errs++;
      $display("FAIL rst_mid_async: got %b tx=%h, required 1100000/00",
               {cmd_ready_o, rx_tready_o, tx_tvalid_o, opnd_ready_o,
                busy_o, rsp_valid_o, rsp_err_o}, tx_tdata_o);
    end
    opq.delete();
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    txq.delete();
    opq.push_back(32'd3); opq.push_back(32'd4);
    tick();
    send_cmd(OP_ADD, 2, hs);
    wait_tx(12, ok);
    checks++;
    if (!ok || txq.size() != 12 || txq[4] !== 8'h03 || txq[8] !== 8'h04) begin
      errs++;
      $display("FAIL rst_mid_tx: got %0d bytes, required 12 with 03/04",
               txq.size());
    end
    feed_rx(32'h00000007, 4, last);
    wait_rsp(20, c);
    checks++;
    if (c < 0 || rsp_data_o !== 32'h7 || rsp_err_o !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_rsp: got data=%h err=%b, required 00000007/0",
               rsp_data_o, rsp_err_o);
    end
    rsp_ack();
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_stall();
    test_invalid();
    test_timeout();
    test_stale_div();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_alu_host.md
Name: uart_alu_host

Overview:
- Host-side initiator for the UART ALU packet protocol, i.e. the other end of the link from the ALU responder.
- Takes one operation command (opcode plus N 32-bit operands) and serializes the request packet as a byte stream into a UART transmitter's AXI-Stream input.
- Collects the 4-byte little-endian result from the UART receiver's AXI-Stream output and returns it as one 32-bit response.
- Used in self-test benches and FPGA loopback builds that drive a uart_alu through a second uart instance.

Parameters:
- MAX_OPS, 8, maximum operands per command (>=2).
- TIMEOUT_CYCLES, 1000000, clk_i cycles allowed between response bytes before aborting.
- CNT_W, $clog2(MAX_OPS+1), width of the operand count.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_opcode_i  in  8  0x01 ADD, 0x02 MUL, 0x03 DIV.
- cmd_count_i  in  CNT_W  number of operands N.
- opnd_valid_i  in  1  operand stream valid.
- opnd_ready_o  out  1  operand stream ready.
- opnd_data_i  in  32  operand value.
- tx_tdata_o  out  8  byte to UART TX.
- tx_tvalid_o  out  1  TX byte valid.
- tx_tready_i  in  1  TX accepts byte.
- rx_tdata_i  in  8  byte from UART RX.
- rx_tvalid_i  in  1  RX byte valid.
- rx_tready_o  out  1  RX byte consumed.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  32  result; 0 when rsp_err_o=1.
- rsp_err_o  out  1  command rejected or timed out.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_ni low): state IDLE. All outputs 0 except cmd_ready_o=1 and rx_tready_o=1. Byte, operand and timeout counters cleared.
- Packet format: opcode, 0x00 (reserved), LEN[7:0], LEN[15:8], then N operands, each 4 bytes LSB first. LEN = 4 + 4*N (16-bit, counts header bytes).
- States: IDLE, HDR, OPND, RESP, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake, latch opcode and N.
  - Valid means opcode in {01,02,03} and 2<=N<=MAX_OPS. Invalid: go to DONE with rsp_err_o=1, rsp_data_o=0; nothing is transmitted.
  - Valid: go to HDR with byte_idx=0.
- HDR:
  - tx_tvalid_o=1, tx_tdata_o=header[byte_idx].
  - byte_idx advances only on tx_tvalid_o&tx_tready_i.
  - After byte 3, go to OPND.
- OPND:
  - opnd_ready_o=1 only when no operand is held. Each accepted operand goes into a 32-bit holding register.
  - Held operand is emitted as 4 bytes LSB first under TX handshake. The next operand may be accepted in the same cycle the 4th byte handshakes, so a fully ready stream gives back-to-back bytes.
  - After operand N's 4th byte, go to RESP with byte_idx=0 and the timeout counter cleared.
- Holding rule: tx_tdata_o is stable while tx_tvalid_o=1 && tx_tready_i=0. tx_tvalid_o never drops without a handshake except on reset.
- RESP:
  - rx_tready_o=1. Each rx handshake writes result[byte_idx*8 +: 8] and clears the timeout counter.
  - After the 4th byte, go to DONE with err=0.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 with no rx byte, go to DONE with err=1 and data=0.
- DONE:
  - rsp_valid_o=1; rsp_data_o and rsp_err_o stay stable until rsp_ready_i.
  - rx_tready_o=0, so at most the UART's internal buffer holds any extra bytes.
  - On handshake, return to IDLE. rsp_valid_o clears on the next cycle.
- rx_tready_o=1 in IDLE, HDR, OPND. Bytes arriving there are stale and are discarded without affecting the result.
- Simultaneous events:
  - cmd_valid_i is ignored outside IDLE.
  - An rx byte in the same cycle the timeout fires is consumed and completes/advances; it takes priority over timeout.
- Reset mid-packet aborts immediately. The downstream ALU recovers through its own reset; no partial-packet recovery is attempted.
- Latency, N=2, all ready: first TX byte the cycle after the cmd handshake; 12 TX cycles; rsp_valid_o the cycle after the 4th rx byte.

Decomposition:
- Package uart_alu_pkg holds:
  - the opcode constants (ECHO 0xEC, ADD 0x01, MUL 0x02, DIV 0x03);
  - HDR_BYTES=4 and the reserved byte value 0x00;
  - a state enum typedef shared with uart_alu.
- One natural sub-module: uart_alu_byte_ser. It is a 32-bit-to-4-byte serializer with a holding register and AXI-Stream out, and is used for the operand phase.
- Header muxing and response assembly stay in the top.

Test Plan:
- ADD N=2 (5, 7), all ready -> TX 01 00 0C 00 05 00 00 00 07 00 00 00; feed RX 0C 00 00 00 -> rsp_data_o=0x0000000C, err=0, one rsp_valid_o pulse held until rsp_ready_i.
- MUL N=3 (0x11223344, 2, 3) with tx_tready_i toggling 1-of-3 cycles -> TX 02 00 10 00 44 33 22 11 02 00 00 00 03 00 00 00; no byte duplicated or changed while stalled.
- cmd_count_i=1 or opcode 0x07 -> no TX activity; rsp_valid_o with err=1, data=0 within 2 cycles.
- TIMEOUT_CYCLES=50, send 2 of 4 RX bytes then idle -> err=1, data=0 exactly 50 cycles after the last byte.
- RX byte 0xAA injected in IDLE and during HDR -> discarded; subsequent DIV 100/7 with RX 0E 00 00 00 -> data=0x0E.
- Assert rst_ni low mid-OPND -> outputs return to reset values asynchronously; a new ADD afterward completes correctly.
